// File: rtl/maze_pkg.sv
// Shared constants, loader state encoding and cell helpers for the maze front end.
package maze_pkg;

  localparam int unsigned ROWS  = 16;
  localparam int unsigned COLS  = 16;
  localparam int unsigned LOC_W = 8;
  localparam int unsigned ROW_W = 4;
  localparam int unsigned COL_W = 4;

  localparam logic WALL = 1'b1;
  localparam logic OPEN = 1'b0;

  localparam logic [LOC_W-1:0] ENTRY_LOC = 8'h00;
  localparam logic [LOC_W-1:0] EXIT_LOC  = 8'hFF;

  typedef enum logic [2:0] {
    StIdle,
    StWaitRow,
    StWrite,
    StKick,
    StDone,
    StErr
  } loader_state_e;

  function automatic logic is_corner(input logic [LOC_W-1:0] loc);
    return (loc == ENTRY_LOC) || (loc == EXIT_LOC);
  endfunction

endpackage

// File: rtl/row_serializer.sv
// Holds one accepted maze row and presents the cell bit picked by the column index.
module row_serializer
  import maze_pkg::*;
#(
  parameter int unsigned WIDTH = COLS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_row,
  input  logic [COL_W-1:0] i_col,
  output logic             o_bit
);

  logic [WIDTH-1:0] r_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf <= '0;
    end else if (i_load) begin
      r_buf <= i_row;
    end
  end

  assign o_bit = r_buf[i_col];

endmodule

// File: rtl/maze_loader.sv
// Loads a maze row by row into solver memory, checks entry/exit cells, then kicks the solver.
module maze_loader #(
  parameter int unsigned ROWS = maze_pkg::ROWS,
  parameter int unsigned COLS = maze_pkg::COLS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [COLS-1:0]            rowIn,
  input  logic                       rowValid,
  output logic                       rowReady,
  output logic [maze_pkg::LOC_W-1:0] memLoc,
  output logic                       memDin,
  output logic                       memWr,
  output logic                       start,
  output logic                       busy,
  output logic                       loaded,
  output logic                       loadErr
);
  import maze_pkg::*;

  localparam logic [ROW_W-1:0] RowLast = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] ColLast = COL_W'(COLS - 1);

  loader_state_e    r_state, w_state_next;
  logic [ROW_W-1:0] r_row, w_row_next;
  logic [COL_W-1:0] r_col, w_col_next;
  logic             r_corner_err, w_corner_err_next;

  logic             r_row_ready;
  logic             r_mem_wr;
  logic             r_start;
  logic             r_busy;
  logic             r_loaded;
  logic             r_load_err;

  logic             w_buf_load;
  logic             w_cell;
  logic [LOC_W-1:0] w_loc;

  assign w_loc = {r_row, r_col};

  row_serializer #(
    .WIDTH(COLS)
  ) u_row_serializer (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_buf_load),
    .i_row (rowIn),
    .i_col (r_col),
    .o_bit (w_cell)
  );

  always_comb begin
    w_state_next      = r_state;
    w_row_next        = r_row;
    w_col_next        = r_col;
    w_corner_err_next = r_corner_err;
    w_buf_load        = 1'b0;

    unique case (r_state)
      StIdle, StDone, StErr: begin
        if (load) begin
          w_state_next      = StWaitRow;
          w_row_next        = '0;
          w_col_next        = '0;
          w_corner_err_next = 1'b0;
        end
      end

      StWaitRow: begin
        if (rowValid && r_row_ready) begin
          w_buf_load   = 1'b1;
          w_col_next   = '0;
          w_state_next = StWrite;
        end
      end

      StWrite: begin
        w_col_next = r_col + COL_W'(1);
        if (is_corner(w_loc) && (w_cell == WALL)) begin
          w_corner_err_next = 1'b1;
        end
        if (r_col == ColLast) begin
          if (r_row != RowLast) begin
            w_row_next   = r_row + ROW_W'(1);
            w_state_next = StWaitRow;
          end else if (w_corner_err_next) begin
            w_state_next = StErr;
          end else begin
            w_state_next = StKick;
          end
        end
      end

      StKick: begin
        w_state_next = StDone;
      end

      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Status outputs are registered decodes of the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_row        <= '0;
      r_col        <= '0;
      r_corner_err <= 1'b0;
      r_row_ready  <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_start      <= 1'b0;
      r_busy       <= 1'b0;
      r_loaded     <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_row        <= w_row_next;
      r_col        <= w_col_next;
      r_corner_err <= w_corner_err_next;
      r_row_ready  <= (w_state_next == StWaitRow);
      r_mem_wr     <= (w_state_next == StWrite);
      r_start      <= (w_state_next == StKick);
      r_busy       <= (w_state_next == StWaitRow) || (w_state_next == StWrite) ||
                      (w_state_next == StKick);
      r_loaded     <= (w_state_next == StDone);
      r_load_err   <= (w_state_next == StErr);
    end
  end

  assign rowReady = r_row_ready;
  assign memWr    = r_mem_wr;
  assign memLoc   = r_mem_wr ? w_loc : '0;
  assign memDin   = r_mem_wr & w_cell;
  assign start    = r_start;
  assign busy     = r_busy;
  assign loaded   = r_loaded;
  assign loadErr  = r_load_err;

endmodule

// File: tb/tb_maze_loader.sv
// Bench for maze_loader: scoreboarded memory-write stream plus directed load scenarios.
module tb_maze_loader;

  typedef struct packed {
    logic [7:0] loc;
    logic       din;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] rowIn;
  logic        rowValid;
  logic        rowReady;
  logic [7:0]  memLoc;
  logic        memDin;
  logic        memWr;
  logic        start;
  logic        busy;
  logic        loaded;
  logic        loadErr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  wr_t         exp_q[$];
  logic        mem [256];
  logic [15:0] rows [16];

  int acc_cnt;
  int first_acc_edge;
  int start_cnt;
  int start_edge;
  int wr_cnt;
  int last_wr_edge;
  int loaded_edge;
  bit loaded_seen;
  int load_edge;

  maze_loader #(
    .ROWS(16),
    .COLS(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .rowIn   (rowIn),
    .rowValid(rowValid),
    .rowReady(rowReady),
    .memLoc  (memLoc),
    .memDin  (memDin),
    .memWr   (memWr),
    .start   (start),
    .busy    (busy),
    .loaded  (loaded),
    .loadErr (loadErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle; an event seen here is captured by the edge cyc+1.
  always @(negedge clk) begin
    wr_t e;
    if (rowValid && rowReady) begin
      if (acc_cnt == 0) first_acc_edge = cyc + 1;
      acc_cnt++;
    end
    if (start) begin
      start_cnt++;
      start_edge = cyc + 1;
    end
    if (loaded && !loaded_seen) begin
      loaded_seen = 1'b1;
      loaded_edge = cyc + 1;
    end
    if (memWr) begin
      mem[memLoc]  = memDin;
      wr_cnt++;
      last_wr_edge = cyc + 1;
      check("ready_low_in_write", int'(rowReady), 0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: loc %02h din %0b, no write required", memLoc, memDin);
      end else begin
        e = exp_q.pop_front();
        check("wr_loc", int'(memLoc), int'(e.loc));
        check("wr_din", int'(memDin), int'(e.din));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load();
    load = 1'b1;
    tick();
    load           = 1'b0;
    load_edge      = cyc;
    acc_cnt        = 0;
    first_acc_edge = 0;
    start_cnt      = 0;
    start_edge     = 0;
    wr_cnt         = 0;
    last_wr_edge   = 0;
    loaded_edge    = 0;
    loaded_seen    = 1'b0;
  endtask

  task automatic push_expected(input int count);
    wr_t e;
    for (int i = 0; i < count; i++) begin
      e.loc = 8'(i);
      e.din = rows[i / 16][i % 16];
      exp_q.push_back(e);
    end
  endtask

  // Held mode keeps rowValid high with the row; throttled mode toggles junk during WRITE
  // and then idles rowValid low for gap cycles before presenting the real row.
  task automatic send_row(input logic [15:0] r, input int gap, input bit toggle);
    int n = 0;
    if (gap == 0 && !toggle) begin
      rowValid = 1'b1;
      rowIn    = r;
    end
    while (!rowReady && n < 64) begin
      if (toggle) begin
        rowValid = ~rowValid;
        rowIn    = 16'hFFFF;
      end
      tick();
      n++;
    end
    check("ready_returned", int'(rowReady), 1);
    if (gap > 0 || toggle) begin
      rowValid = 1'b0;
      repeat (gap) tick();
      rowValid = 1'b1;
      rowIn    = r;
    end
    tick();
  endtask

  task automatic send_all(input int gap, input bit toggle, input int inject);
    for (int i = 0; i < 16; i++) begin
      send_row(rows[i], gap, toggle);
      if (i == inject) begin
        load = 1'b1;
        tick();
        load = 1'b0;
      end
    end
    rowValid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(loaded || loadErr) && n < 400) begin
      tick();
      n++;
    end
    check("load_finished", int'(loaded | loadErr), 1);
    tick();
    tick();
  endtask

  task automatic set_open();
    for (int r = 0; r < 16; r++) rows[r] = 16'h0000;
  endtask

  task automatic set_pattern();
    for (int r = 0; r < 16; r++) rows[r] = 16'h5554 ^ 16'(r);
    rows[0][0]   = 1'b0;
    rows[15][15] = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rowReady"}, int'(rowReady), 0);
    check({tag, "_memLoc"},   int'(memLoc),   0);
    check({tag, "_memDin"},   int'(memDin),   0);
    check({tag, "_memWr"},    int'(memWr),    0);
    check({tag, "_start"},    int'(start),    0);
    check({tag, "_busy"},     int'(busy),     0);
    check({tag, "_loaded"},   int'(loaded),   0);
    check({tag, "_loadErr"},  int'(loadErr),  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst      = 1'b1;
    load     = 1'b0;
    rowValid = 1'b0;
    rowIn    = 16'h0000;
    acc_cnt  = 0;
    start_cnt = 0;
    wr_cnt   = 0;
    loaded_seen = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // All-open maze with rowValid held high: exact cycle positions from the load edge.
    set_open();
    push_expected(256);
    do_load();
    check("open_busy", int'(busy), 1);
    check("open_ready", int'(rowReady), 1);
    send_all(0, 1'b0, -1);
    wait_done();
    check("open_first_accept", first_acc_edge - load_edge, 1);
    check("open_last_write", last_wr_edge - load_edge, 272);
    check("open_start_edge", start_edge - load_edge, 273);
    check("open_loaded_edge", loaded_edge - load_edge, 274);
    check("open_start_cnt", start_cnt, 1);
    check("open_wr_cnt", wr_cnt, 256);
    check("open_loaded", int'(loaded), 1);
    check("open_loadErr", int'(loadErr), 0);
    check("open_busy_end", int'(busy), 0);
    check("open_queue_empty", exp_q.size(), 0);

    // Reload from DONE with a patterned maze; a load during WRITE must be ignored.
    set_pattern();
    push_expected(256);
    do_load();
    check("reload_drops_loaded", int'(loaded), 0);
    send_all(0, 1'b0, 3);
    wait_done();
    check("pat_start_cnt", start_cnt, 1);
    check("pat_start_edge", start_edge - load_edge, 273);
    check("pat_accepts", acc_cnt, 16);
    check("pat_loaded", int'(loaded), 1);
    check("pat_queue_empty", exp_q.size(), 0);
    check("pat_loc01", int'(mem[8'h01]), 0);
    check("pat_loc02", int'(mem[8'h02]), 1);
    for (int i = 0; i < 256; i++) begin
      check("pat_readback", int'(mem[i]), int'(rows[i / 16][i % 16]));
    end

    // Blocked exit: cell (15,15) walled ends in ERR without a start pulse.
    set_open();
    rows[15] = 16'h8000;
    push_expected(256);
    do_load();
    check("blk_drops_loaded", int'(loaded), 0);
    send_all(0, 1'b0, -1);
    wait_done();
    check("blk_loadErr", int'(loadErr), 1);
    check("blk_loaded", int'(loaded), 0);
    check("blk_start_cnt", start_cnt, 0);
    check("blk_busy", int'(busy), 0);
    check("blk_queue_empty", exp_q.size(), 0);

    // Throttled source from ERR: gaps before each row, junk rowValid toggling during WRITE.
    for (int r = 0; r < 16; r++) rows[r] = 16'hA5C3 ^ (16'(r) << 8) ^ 16'(r * 3);
    rows[0][0]   = 1'b0;
    rows[15][15] = 1'b0;
    push_expected(256);
    do_load();
    check("thr_clears_loadErr", int'(loadErr), 0);
    check("thr_busy", int'(busy), 1);
    send_all(5, 1'b1, -1);
    wait_done();
    check("thr_accepts", acc_cnt, 16);
    check("thr_start_cnt", start_cnt, 1);
    check("thr_loaded", int'(loaded), 1);
    check("thr_queue_empty", exp_q.size(), 0);

    // Reset during the row 7 / col 3 write, then a clean full load.
    set_pattern();
    push_expected(7 * 16 + 4);
    do_load();
    for (int i = 0; i < 8; i++) send_row(rows[i], 0, 1'b0);
    n = 0;
    while (!(memWr && memLoc == 8'h73) && n < 32) begin
      tick();
      n++;
    end
    check("rst_reached_73", int'(memLoc), 8'h73);
    rst      = 1'b1;
    rowValid = 1'b0;
    tick();
    check_idle_outputs("midrst");
    rst = 1'b0;
    repeat (5) tick();
    check("midrst_no_start", start_cnt, 0);
    check("midrst_queue_empty", exp_q.size(), 0);
    check("midrst_still_idle", int'(busy), 0);

    push_expected(256);
    do_load();
    send_all(0, 1'b0, -1);
    wait_done();
    check("post_start_cnt", start_cnt, 1);
    check("post_start_edge", start_edge - load_edge, 273);
    check("post_loaded", int'(loaded), 1);
    check("post_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/maze_loader.md
# maze_loader

Front-end stage for the rat-in-maze solver. It accepts the maze one 16-bit row at a time over a valid/ready handshake, writes every cell bit into maze memory through the memory's write port, and checks that the entry and exit cells are open. It then pulses the solver's `start`. It sits directly upstream of the solver top and owns the memory write path while loading.

## Interface

Parameters:
- `ROWS`, default 16: maze rows; row index width 4.
- `COLS`, default 16: maze columns; column index width 4; equals the `rowIn` width.

Ports:
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `load` input 1: request to begin loading; sampled in IDLE, DONE and ERR.
- `rowIn` input 16: one maze row; bit c is column c; 1 means wall, 0 means open.
- `rowValid` input 1: `rowIn` is valid.
- `rowReady` output 1: loader can accept a row this cycle.
- `memLoc` output 8: memory address {row[3:0], col[3:0]}; same format as the solver's location.
- `memDin` output 1: cell bit to write.
- `memWr` output 1: memory write strobe; one cell per cycle.
- `start` output 1: one-cycle pulse to the solver after a successful load.
- `busy` output 1: load in progress.
- `loaded` output 1: a valid maze is resident.
- `loadErr` output 1: the last load had cell (0,0) or cell (15,15) walled.

## Operation

- States: IDLE, WAIT_ROW, WRITE, KICK, DONE, ERR.
- IDLE: when `load`=1, go to WAIT_ROW. Set row counter to 0 and clear the corner-error flag.
- WAIT_ROW:
  - `rowReady`=1.
  - When `rowValid`=1, latch `rowIn` into the row shift register, set col=0, and go to WRITE.
- WRITE:
  - Each cycle: `memWr`=1, `memLoc`={row,col}, `memDin`=rowBuf[col].
  - Then col increments.
  - When writing row 0/col 0 or row 15/col 15: if `memDin`=1, set the corner-error flag.
  - After col 15:
    - If row<15: increment row and go to WAIT_ROW.
    - If row=15 and the flag is clear: go to KICK.
    - If row=15 and the flag is set: go to ERR.
- KICK: `start`=1 for exactly one cycle, then go to DONE.
- DONE: `loaded`=1. A new `load` goes to WAIT_ROW and drops `loaded` in that cycle.
- ERR: `loadErr`=1. No `start` is issued. A new `load` restarts the load and clears `loadErr`.
- `busy`=1 in WAIT_ROW, WRITE and KICK.
- `load` asserted while `busy` is ignored.
- Counters are 4-bit. Col wraps 15→0 only via the row advance. Row never wraps; end of load is decided at row 15.
- `rowValid` during WRITE is not acknowledged. The upstream source must hold its row until it sees `rowReady`.

## Timing

- Reset value of every output is 0: `rowReady`, `memLoc`, `memDin`, `memWr`, `start`, `busy`, `loaded`, `loadErr`. State goes to IDLE.
- Handshake: a transfer occurs on the rising edge where `rowValid` and `rowReady` are both 1. `rowReady` is a registered state decode.
- Per-row timing:
  - First `memWr` for the row is the cycle after acceptance.
  - The row takes 16 consecutive write cycles.
  - `rowReady` returns the cycle after the col-15 write.
- Full load with `rowValid` held high:
  - `load` seen at cycle 0; first acceptance at cycle 1.
  - Last write at cycle 272.
  - `start` at cycle 273; `loaded` from cycle 274.
- `memLoc`/`memDin`/`memWr` are registered and aligned in the same cycle. The memory captures on the following edge.
- Reset mid-load: the loader returns to IDLE the next cycle. Memory is not cleared; partially written contents are simply not valid. `start` never fires.
- `memWr` is 0 outside WRITE, so the solver's own memory writes are not disturbed once `start` has pulsed. The top-level mux gives the loader the memory while `busy`=1.

## Structure

- Shared package `maze_pkg`:
  - Constants: ROWS, COLS, LOC_W=8, ROW_W=4, COL_W=4.
  - Loader state enum.
  - Wall/open encoding constants: WALL=1, OPEN=0.
  - Entry/exit location constants: 8'h00 and 8'hFF.
- One sub-module: `row_serializer`. It is a 16-bit load-and-index register with a `load` strobe and a 4-bit column select, and outputs the selected bit.
- The FSM and counters live in `maze_loader`.

## Test plan

- All-open maze: `load` once, then 16 rows of 16'h0000 with `rowValid` held high. Required: 256 writes at addresses 0x00..0xFF in order, all `memDin`=0. `start` pulses once at cycle 273, then `loaded`=1 and `loadErr`=0.
- Patterned maze:
  - Row r = 16'h5554 ^ r, with bit 0 of row 0 and bit 15 of row 15 cleared.
  - Required: the memory model reads back each cell equal to the sent bit, e.g. loc 0x01 = 0 and loc 0x02 = 1.
- Blocked exit: row 15 = 16'h8000. Required: ERR reached, `loadErr`=1, no `start` pulse, `loaded`=0.
- Throttled source:
  - `rowValid` is low for 5 cycles before each row.
  - `rowValid` is also toggled during WRITE.
  - Required: exactly 16 acceptances, no row dropped or duplicated, `rowReady`=0 throughout every WRITE.
- Reset mid-load: assert `rst` during the row 7/col 3 write. Required: all outputs 0 the next cycle and no `start`. A subsequent full load completes normally.
- Reload:
  - `load` again in DONE; also `load` asserted during WRITE.
  - Required: the mid-WRITE `load` is ignored. The DONE reload drops `loaded` and completes a second load with a single `start`.
